bin2bcd_converter_4: RTL and testbench

//   Converts an unsigned binary word to four packed BCD digits (ones..thousands)
//   for the 7-segment display path. The conversion is combinational double-dabble
//   (shift-and-add-3) and the digits are registered once, giving one clock of latency.
//   It sits between the binary counter/ALU datapath and the display multiplexer.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_add3_cell.sv | 12 +
 rtl/bin2bcd_converter_4.sv | 52 +++++
 tb/tb_bin2bcd_converter_4.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
package bcd_pkg;
  localparam int BCD_DIGIT_W    = 4;
  localparam int NUM_BCD_DIGITS = 4;
  localparam int DEC_MOD        = 10000;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t value,
  output bcd_digit_t adjusted
);

  assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin2bcd_converter_4.sv
// Binary to four-digit packed BCD for the 7-segment path: combinational
// shift-and-add-3 network, then one register stage with async clear.
module bin2bcd_converter_4
  import bcd_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic [INPUT_BIT_WIDTH-1:0] Input,
  output logic [0:3]                 Digit0,
  output logic [0:3]                 Digit1,
  output logic [0:3]                 Digit2,
  output logic [0:3]                 Digit3
);

  localparam int BCD_W = NUM_BCD_DIGITS * BCD_DIGIT_W;

  logic [BCD_W-1:0] bcd [0:INPUT_BIT_WIDTH];
  logic [BCD_W-1:0] digits_q;

  assign bcd[0] = '0;

  for (genvar s = 0; s < INPUT_BIT_WIDTH; s++) begin : g_stage
    logic [BCD_W-1:0] adjusted;

    for (genvar d = 0; d < NUM_BCD_DIGITS; d++) begin : g_digit
      bcd_add3_cell u_cell (
        .value    (bcd[s][d*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adjusted (adjusted[d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end

    // Carry out of the thousands digit is worth 10000, so discarding it
    // each shift yields the value modulo 10000 directly.
    assign bcd[s+1] = BCD_W'({adjusted, Input[INPUT_BIT_WIDTH-1-s]});
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      digits_q <= '0;
    end else begin
      digits_q <= bcd[INPUT_BIT_WIDTH];
    end
  end

  assign Digit0 = digits_q[3:0];
  assign Digit1 = digits_q[7:4];
  assign Digit2 = digits_q[11:8];
  assign Digit3 = digits_q[15:12];

endmodule

// File: tb/tb_bin2bcd_converter_4.sv
// Scoreboard bench for bin2bcd_converter_4: stimulus pushes the decimal
// reference result, a monitor pops and compares after every loading edge.
module tb_bin2bcd_converter_4;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         nReset = 1'b1;
  logic [W-1:0] Input = '0;
  logic [0:3]   Digit0, Digit1, Digit2, Digit3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  bin2bcd_converter_4 #(.INPUT_BIT_WIDTH(W)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .Input  (Input),
    .Digit0 (Digit0),
    .Digit1 (Digit1),
    .Digit2 (Digit2),
    .Digit3 (Digit3)
  );

  always #5 Clk = ~Clk;

  // Reference: decimal digits of value mod 10000, packed D3..D0.
  function automatic logic [15:0] model(int unsigned value);
    int unsigned v;
    int unsigned p;
    logic [15:0] r;
    v = value % 10000;
    p = 1;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] actual();
    return {Digit3, Digit2, Digit1, Digit0};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got D3..D0=%h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input logic [15:0] got);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (got[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL digit_range: got D3..D0=%h required every digit <= 9", got);
    end
  endtask

  task automatic apply(input int unsigned value);
    @(negedge Clk);
    Input = W'(value);
    exp_q.push_back(model(value % (1 << W)));
  endtask

  // Monitor: every rising edge out of reset presents a new conversion.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge Clk);
      if (nReset) begin
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("scoreboard", actual(), e);
          check_range(actual());
        end
      end
    end
  end

  initial begin
    int unsigned directed [] = '{0, 10, 142, 89, 33, 599, 9999, 10000, 65535};

    // Asynchronous clear with no clock edge yet
    Input = 16'd1234;
    #1 nReset = 1'b0;
    #1 check("reset_no_clk", actual(), 16'h0000);
    @(posedge Clk);
    #1 check("reset_held", actual(), 16'h0000);
    @(negedge Clk);
    nReset = 1'b1;
    exp_q.push_back(model(1234));

    foreach (directed[i]) apply(directed[i]);

    // Back-to-back with a glitch between edges
    apply(7);
    @(posedge Clk);
    #2 Input = 16'd3;
    #1 check("glitch_hold", actual(), model(7));
    apply(8);
    apply(9);

    // Mid-stream asynchronous reset
    apply(4321);
    @(posedge Clk);
    #3 nReset = 1'b0;
    #1 check("midstream_clear", actual(), 16'h0000);
    @(posedge Clk);
    #1 check("midstream_held", actual(), 16'h0000);
    @(negedge Clk);
    nReset = 1'b1;
    exp_q.push_back(model(4321));

    for (int v = 0; v < 10000; v++) apply(v);

    repeat (400) apply($urandom_range(0, 65535));

    repeat (3) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
